am2940_ctrl: RTL and testbench

- Instruction decoder and transfer sequencer for the 8-bit DMA address generator.
- Accepts 3-bit microinstructions and holds the control register plus the address and word-count shadow registers.
- Drives the command side (pl/inc/dec/encnt) of an external address counter and word counter, both existing 8-bit up/down counters whose ci is tied low.
- Senses the counter values, steps the counters during a transfer, flags DONE at the terminal count, and multiplexes readback data.

---
 rtl/am2940_pkg.sv | 39 +++
 rtl/am2940_done_det.sv | 32 +++
 rtl/am2940_ctrl.sv | 159 +++++++++++++++
 tb/tb_am2940_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/am2940_pkg.sv
// Shared types for the 8-bit DMA address generator control block:
// instruction codes, word-count modes, control register layout and sequencer states.
package am2940_pkg;

    typedef enum logic [2:0] {
        WR_CR   = 3'd0,
        RD_CR   = 3'd1,
        RD_WC   = 3'd2,
        RD_ADDR = 3'd3,
        REINIT  = 3'd4,
        LD_ADDR = 3'd5,
        LD_WC   = 3'd6,
        ENABLE  = 3'd7
    } instr_e;

    typedef enum logic [1:0] {
        WC_ZERO  = 2'd0,
        WC_CMP   = 2'd1,
        ADDR_CMP = 2'd2,
        WC_FREE  = 2'd3
    } mode_e;

    typedef struct packed {
        logic  dir;
        mode_e mode;
    } cr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counting-up modes start the word counter at zero and compare against wc_reg.
    function automatic logic wc_loads_zero(input mode_e m);
        return (m == WC_CMP) || (m == WC_FREE);
    endfunction

endpackage

// File: rtl/am2940_done_det.sv
// Terminal-count detector: decides whether the step being issued this cycle
// is the last one of the transfer, given the current counter values.
module am2940_done_det
    import am2940_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [1:0]   mode,
    input  logic         dir,
    input  logic [W-1:0] addr_q,
    input  logic [W-1:0] wc_q,
    input  logic [W-1:0] wc_reg,
    output logic         term
);

    logic [W-1:0] addr_next;
    logic [W-1:0] wc_next;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        term      = 1'b0;
        addr_next = dir ? (addr_q - W'(1)) : (addr_q + W'(1));
        wc_next   = wc_q + W'(1);
        case (mode_e'(mode))
            WC_ZERO:  term = (wc_q == W'(1));
            WC_CMP:   term = (wc_next == wc_reg);
            ADDR_CMP: term = (addr_next == wc_reg);
            default:  term = 1'b0;
        endcase
    end

endmodule

// File: rtl/am2940_ctrl.sv
// Instruction decoder and transfer sequencer: drives load/step commands to the
// external address and word counters and flags DONE at the terminal count.
module am2940_ctrl
    import am2940_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   instr,
    input  logic         instr_valid,
    input  logic         cnte_n,
    input  logic [W-1:0] di,
    output logic [W-1:0] dout,
    output logic         dout_oe,
    input  logic [W-1:0] addr_q,
    input  logic [W-1:0] wc_q,
    output logic         addr_pl,
    output logic         addr_inc,
    output logic         addr_dec,
    output logic         addr_encnt,
    output logic [W-1:0] addr_di,
    output logic         wc_pl,
    output logic         wc_inc,
    output logic         wc_dec,
    output logic         wc_encnt,
    output logic [W-1:0] wc_di,
    output logic         busy,
    output logic         done
);

    cr_t          cr;
    logic [W-1:0] addr_reg;
    logic [W-1:0] wc_reg;
    state_e       state;
    logic         done_q;

    instr_e op;
    logic   is_load;
    logic   step;
    logic   term;

    assign op      = instr_e'(instr);
    assign is_load = instr_valid && (op inside {WR_CR, REINIT, LD_ADDR, LD_WC});
    assign step    = (state == RUN) && !cnte_n && !is_load;
    assign busy    = (state == RUN);
    assign done    = done_q;

    am2940_done_det #(.W(W)) u_done_det (
        .mode   (cr.mode),
        .dir    (cr.dir),
        .addr_q (addr_q),
        .wc_q   (wc_q),
        .wc_reg (wc_reg),
        .term   (term)
    );

    // Counter commands are combinational so a load lands on the same edge that samples instr.
    always_comb begin
        addr_pl    = 1'b0;
        addr_inc   = 1'b0;
        addr_dec   = 1'b0;
        addr_encnt = 1'b0;
        addr_di    = '0;
        wc_pl      = 1'b0;
        wc_inc     = 1'b0;
        wc_dec     = 1'b0;
        wc_encnt   = 1'b0;
        wc_di      = '0;
        dout       = '0;
        dout_oe    = 1'b0;

        if (instr_valid) begin
            case (op)
                RD_CR: begin
                    dout    = {{(W-3){1'b0}}, cr};
                    dout_oe = 1'b1;
                end
                RD_WC: begin
                    dout    = wc_q;
                    dout_oe = 1'b1;
                end
                RD_ADDR: begin
                    dout    = addr_q;
                    dout_oe = 1'b1;
                end
                REINIT: begin
                    addr_pl = 1'b1;
                    addr_di = addr_reg;
                    wc_pl   = 1'b1;
                    wc_di   = wc_loads_zero(cr.mode) ? '0 : wc_reg;
                end
                LD_ADDR: begin
                    addr_pl = 1'b1;
                    addr_di = di;
                end
                LD_WC: begin
                    wc_pl = 1'b1;
                    wc_di = wc_loads_zero(cr.mode) ? '0 : di;
                end
                default: ;
            endcase
        end

        if (step) begin
            addr_encnt = 1'b1;
            addr_inc   = !cr.dir;
            addr_dec   = cr.dir;
            case (cr.mode)
                WC_ZERO: begin
                    wc_encnt = 1'b1;
                    wc_dec   = 1'b1;
                end
                WC_CMP, WC_FREE: begin
                    wc_encnt = 1'b1;
                    wc_inc   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: reset is sampled on the clock edge only; it is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            cr       <= '0;
            addr_reg <= '0;
            wc_reg   <= '0;
            state    <= IDLE;
            done_q   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all updates share one edge.
            if (instr_valid) begin
                case (op)
                    WR_CR:   cr       <= cr_t'(di[2:0]);
                    LD_ADDR: addr_reg <= di;
                    LD_WC:   wc_reg   <= di;
                    default: ;
                endcase
            end

            if (is_load) begin
                state  <= IDLE;
                done_q <= 1'b0;
            end else if (instr_valid && (op == ENABLE) && (state == IDLE)) begin
                if ((cr.mode == WC_ZERO) && (wc_q == '0)) begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end else begin
                    state <= RUN;
                end
            end else if (step && term) begin
                state  <= DONE;
                done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_am2940_ctrl.sv
// Self-checking bench for am2940_ctrl: behavioural address/word counters close the
// loop, a vector table drives the main sequences, hand sequences cover long runs and reset.
module tb_am2940_ctrl;
    import am2940_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   instr = 3'd0;
    logic         instr_valid = 1'b0;
    logic         cnte_n = 1'b1;
    logic [W-1:0] di = '0;
    logic [W-1:0] dout;
    logic         dout_oe;
    logic [W-1:0] addr_q = '0;
    logic [W-1:0] wc_q = '0;
    logic         addr_pl, addr_inc, addr_dec, addr_encnt;
    logic [W-1:0] addr_di;
    logic         wc_pl, wc_inc, wc_dec, wc_encnt;
    logic [W-1:0] wc_di;
    logic         busy, done;
    logic [7:0]   cmd_act;

    assign cmd_act = {addr_pl, addr_inc, addr_dec, addr_encnt, wc_pl, wc_inc, wc_dec, wc_encnt};

    am2940_ctrl #(.W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .cnte_n      (cnte_n),
        .di          (di),
        .dout        (dout),
        .dout_oe     (dout_oe),
        .addr_q      (addr_q),
        .wc_q        (wc_q),
        .addr_pl     (addr_pl),
        .addr_inc    (addr_inc),
        .addr_dec    (addr_dec),
        .addr_encnt  (addr_encnt),
        .addr_di     (addr_di),
        .wc_pl       (wc_pl),
        .wc_inc      (wc_inc),
        .wc_dec      (wc_dec),
        .wc_encnt    (wc_encnt),
        .wc_di       (wc_di),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // External 8-bit up/down counters with ci tied low.
    always @(posedge clk) begin
        if (addr_pl)         addr_q <= addr_di;
        else if (addr_encnt) addr_q <= addr_inc ? addr_q + 8'd1 : (addr_dec ? addr_q - 8'd1 : addr_q);
        if (wc_pl)           wc_q <= wc_di;
        else if (wc_encnt)   wc_q <= wc_inc ? wc_q + 8'd1 : (wc_dec ? wc_q - 8'd1 : wc_q);
    end

    typedef struct {
        logic [2:0] instr;
        logic       valid;
        logic [7:0] di;
        logic       cnte_n;
        logic [7:0] cmd;
        logic [7:0] adi;
        logic [7:0] wdi;
        logic [7:0] dout;
        logic       oe;
        logic       busy;
        logic       done;
        logic [7:0] a;
        logic [7:0] w;
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input string name, input logic [63:0] v);
        exp_t e;
        e.name = name;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [63:0] act);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_underflow: got %0h expected <none>", act);
        end else begin
            e = sb.pop_front();
            check(e.name, act, e.val);
        end
    endtask

    task automatic check_inv(input string name);
        check(name, {addr_inc & addr_dec, wc_inc & wc_dec, addr_pl & addr_encnt, wc_pl & wc_encnt}, 64'd0);
    endtask

    function automatic vec_t v(input logic [2:0] i, input logic val, input logic [7:0] d,
                               input logic c, input logic [7:0] cmd, input logic [7:0] adi,
                               input logic [7:0] wdi, input logic [7:0] dt, input logic oe,
                               input logic bz, input logic dn, input logic [7:0] a,
                               input logic [7:0] w);
        vec_t r;
        r.instr = i;   r.valid = val; r.di = d;     r.cnte_n = c;
        r.cmd = cmd;   r.adi = adi;   r.wdi = wdi;  r.dout = dt;  r.oe = oe;
        r.busy = bz;   r.done = dn;   r.a = a;      r.w = w;
        return r;
    endfunction

    // Called at a falling edge: drive, check comb outputs before the rising edge,
    // then check registered flags and counter values at the next falling edge.
    task automatic run_row(input vec_t r, input int idx);
        instr       = r.instr;
        instr_valid = r.valid;
        di          = r.di;
        cnte_n      = r.cnte_n;
        sb_push($sformatf("row%0d_comb", idx), {r.cmd, r.adi, r.wdi, r.dout, r.oe});
        sb_push($sformatf("row%0d_seq", idx), {r.busy, r.done, r.a, r.w});
        #4;
        sb_check({cmd_act, addr_di, wc_di, dout, dout_oe});
        check_inv($sformatf("row%0d_inv", idx));
        @(negedge clk);
        sb_check({busy, done, addr_q, wc_q});
    endtask

    task automatic do_op(input logic [2:0] code, input logic [7:0] d);
        instr       = code;
        di          = d;
        instr_valid = 1'b1;
        cnte_n      = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps;

        //                instr    vl di     cn cmd    adi    wdi    dout   oe bz dn a      w
        // Reset state, readback and mode 0 incrementing transfer of 3 words
        vecs.push_back(v(WR_CR,   0, 8'h55, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00));
        vecs.push_back(v(RD_CR,   1, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00));
        vecs.push_back(v(WR_CR,   1, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00));
        vecs.push_back(v(LD_ADDR, 1, 8'h10, 1, 8'h80, 8'h10, 8'h00, 8'h00, 0, 0, 0, 8'h10, 8'h00));
        vecs.push_back(v(LD_WC,   1, 8'h03, 1, 8'h08, 8'h00, 8'h03, 8'h00, 0, 0, 0, 8'h10, 8'h03));
        vecs.push_back(v(RD_ADDR, 1, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h10, 1, 0, 0, 8'h10, 8'h03));
        vecs.push_back(v(RD_WC,   1, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h03, 1, 0, 0, 8'h10, 8'h03));
        vecs.push_back(v(ENABLE,  1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h10, 8'h03));
        vecs.push_back(v(ENABLE,  0, 8'h00, 0, 8'h53, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h11, 8'h02));
        vecs.push_back(v(ENABLE,  0, 8'h00, 0, 8'h53, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h12, 8'h01));
        vecs.push_back(v(ENABLE,  0, 8'h00, 0, 8'h53, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h13, 8'h00));
        vecs.push_back(v(ENABLE,  0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h13, 8'h00));
        vecs.push_back(v(ENABLE,  1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h13, 8'h00));
        vecs.push_back(v(RD_CR,   1, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 1, 8'h13, 8'h00));
        // Mode 1 decrementing address: wc loads 0 and counts up to wc_reg, address wraps
        vecs.push_back(v(WR_CR,   1, 8'h05, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h13, 8'h00));
        vecs.push_back(v(LD_ADDR, 1, 8'h01, 1, 8'h80, 8'h01, 8'h00, 8'h00, 0, 0, 0, 8'h01, 8'h00));
        vecs.push_back(v(LD_WC,   1, 8'h04, 1, 8'h08, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h01, 8'h00));
        vecs.push_back(v(ENABLE,  1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h01, 8'h00));
        vecs.push_back(v(ENABLE,  0, 8'h00, 0, 8'h35, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h01));
        vecs.push_back(v(ENABLE,  0, 8'h00, 0, 8'h35, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'hFF, 8'h02));
        vecs.push_back(v(ENABLE,  0, 8'h00, 0, 8'h35, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'hFE, 8'h03));
        vecs.push_back(v(ENABLE,  0, 8'h00, 0, 8'h35, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'hFD, 8'h04));
        vecs.push_back(v(RD_ADDR, 1, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'hFD, 1, 0, 1, 8'hFD, 8'h04));
        vecs.push_back(v(RD_WC,   1, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h04, 1, 0, 1, 8'hFD, 8'h04));
        // Mode 2: address compared against wc_reg; cnte_n high pauses stepping
        vecs.push_back(v(WR_CR,   1, 8'h02, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFD, 8'h04));
        vecs.push_back(v(LD_ADDR, 1, 8'hFE, 1, 8'h80, 8'hFE, 8'h00, 8'h00, 0, 0, 0, 8'hFE, 8'h04));
        vecs.push_back(v(LD_WC,   1, 8'h02, 1, 8'h08, 8'h00, 8'h02, 8'h00, 0, 0, 0, 8'hFE, 8'h02));
        vecs.push_back(v(ENABLE,  1, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'hFE, 8'h02));
        vecs.push_back(v(ENABLE,  0, 8'h00, 0, 8'h50, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'hFF, 8'h02));
        vecs.push_back(v(ENABLE,  0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'hFF, 8'h02));
        vecs.push_back(v(ENABLE,  0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'hFF, 8'h02));
        vecs.push_back(v(ENABLE,  0, 8'h00, 0, 8'h50, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h02));
        vecs.push_back(v(ENABLE,  0, 8'h00, 0, 8'h50, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h01, 8'h02));
        vecs.push_back(v(ENABLE,  0, 8'h00, 0, 8'h50, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h02, 8'h02));
        // Mode 0 with an empty word count goes straight to DONE without stepping
        vecs.push_back(v(WR_CR,   1, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h02, 8'h02));
        vecs.push_back(v(LD_WC,   1, 8'h00, 1, 8'h08, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h02, 8'h00));
        vecs.push_back(v(ENABLE,  1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h02, 8'h00));
        vecs.push_back(v(ENABLE,  0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h02, 8'h00));
        // Control register readback is a one-cycle strobe
        vecs.push_back(v(WR_CR,   1, 8'h06, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h02, 8'h00));
        vecs.push_back(v(RD_CR,   1, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h06, 1, 0, 0, 8'h02, 8'h00));
        vecs.push_back(v(RD_CR,   0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h02, 8'h00));
        // Mode 3 free run, REINIT abort, ENABLE while running, WR_CR abort
        vecs.push_back(v(WR_CR,   1, 8'h03, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h02, 8'h00));
        vecs.push_back(v(LD_ADDR, 1, 8'h40, 1, 8'h80, 8'h40, 8'h00, 8'h00, 0, 0, 0, 8'h40, 8'h00));
        vecs.push_back(v(LD_WC,   1, 8'h09, 1, 8'h08, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h40, 8'h00));
        vecs.push_back(v(ENABLE,  1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h40, 8'h00));
        vecs.push_back(v(ENABLE,  0, 8'h00, 0, 8'h55, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h41, 8'h01));
        vecs.push_back(v(ENABLE,  0, 8'h00, 0, 8'h55, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h42, 8'h02));
        vecs.push_back(v(ENABLE,  0, 8'h00, 0, 8'h55, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h43, 8'h03));
        vecs.push_back(v(REINIT,  1, 8'h00, 0, 8'h88, 8'h40, 8'h00, 8'h00, 0, 0, 0, 8'h40, 8'h00));
        vecs.push_back(v(ENABLE,  0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h40, 8'h00));
        vecs.push_back(v(ENABLE,  1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h40, 8'h00));
        vecs.push_back(v(ENABLE,  1, 8'h00, 0, 8'h55, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h41, 8'h01));
        vecs.push_back(v(WR_CR,   1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h41, 8'h01));

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], i);
        instr_valid = 1'b0;
        cnte_n      = 1'b1;
        @(negedge clk);

        // Mode 1 with wc_reg=0: the word counter must go all the way round (256 steps).
        do_op(WR_CR, 8'h01);
        do_op(LD_ADDR, 8'h00);
        do_op(LD_WC, 8'h00);
        do_op(ENABLE, 8'h00);
        sb_push("mode1_wrap_steps", 64'd256);
        sb_push("mode1_wrap_done", 64'd1);
        sb_push("mode1_wrap_addr", 64'h00);
        sb_push("mode1_wrap_wc", 64'h00);
        cnte_n = 1'b0;
        steps  = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            #4;
            if (addr_encnt) steps++;
            @(negedge clk);
        end
        cnte_n = 1'b1;
        sb_check(steps);
        sb_check(done);
        sb_check(addr_q);
        sb_check(wc_q);

        // Reset mid-RUN aborts the transfer and clears the control register.
        do_op(WR_CR, 8'h07);
        do_op(ENABLE, 8'h00);
        cnte_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_busy_before_reset", busy, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_busy_done", {busy, done}, 64'd0);
        reset  = 1'b0;
        cnte_n = 1'b1;
        instr       = RD_CR;
        instr_valid = 1'b1;
        #4;
        check("reset_cr_readback", {dout, dout_oe}, {8'h00, 1'b1});
        check("reset_no_step", cmd_act, 64'd0);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
